// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ST_Z = 0;
    localparam int ST_C = 1;
    localparam int ST_W = 16;

endpackage

// File: rtl/mul_seq_add.sv
// Combinational RW-bit adder with carry-out; the single shared datapath adder.
module mul_seq_add #(
    parameter int RW = 16
) (
    input  logic [RW-1:0] a,
    input  logic [RW-1:0] b,
    output logic [RW-1:0] sum,
    output logic          cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller: one multiplier bit per clock.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN ends RUN once the multiplier has no set bits left.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W  = 4,
    parameter int RW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    output logic            busy,
    output logic            done,
    output logic [RW-1:0]   result,
    output logic [ST_W-1:0] acc_status,
    output state_t          dbg_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // Handshake: start is accepted only in IDLE or DONE (A/B captured then);
    // busy is high for every RUN cycle; done pulses for the single DONE cycle,
    // and result/acc_status are valid from that cycle until the next DONE.
    state_t          state_q, state_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplr_q, mplr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [RW-1:0]   result_q, result_d;
    logic [ST_W-1:0] status_q, status_d;

    logic [RW-1:0]   add_sum;
    logic            add_cout;
    logic            accept;
    logic            last_step;

    mul_seq_add #(.RW(RW)) u_add (
        .a    (acc_q),
        .b    (mcand_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        result_d  = result_q;
        status_d  = status_q;
        last_step = 1'b0;
        accept    = start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                if (mplr_q[0]) begin
                    acc_d   = add_sum;
                    carry_d = carry_q | add_cout;
                end
                mcand_d   = mcand_q << 1;
                mplr_d    = mplr_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                last_step = (cnt_q == CW'(W - 1));
`ifdef MUL_SEQ_EARLY_EXIT_EN
                last_step = last_step || (mplr_d == '0);
`endif
                if (last_step) begin
                    state_d         = DONE;
                    result_d        = acc_d;
                    status_d        = '0;
                    status_d[ST_Z]  = (acc_d == '0);
                    status_d[ST_C]  = carry_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept overrides the IDLE/DONE exits, giving back-to-back operation from DONE.
        if (accept) begin
            state_d = RUN;
            mcand_d = {{(RW - W){1'b0}}, A};
            mplr_d  = B;
            acc_d   = '0;
            cnt_d   = '0;
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign acc_status = status_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and exhaustive bench for mul_seq_ctrl (W=4, RW=16).
module tb_mul_seq_ctrl;
    import mul_seq_pkg::*;

    localparam int W  = 4;
    localparam int RW = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic            busy;
    logic            done;
    logic [RW-1:0]   result;
    logic [ST_W-1:0] acc_status;
    state_t          dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 0;
    logic [RW-1:0] exp_q[$];

    mul_seq_ctrl #(.W(W), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .acc_status (acc_status),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Number of RUN cycles the selected build should take for multiplier b.
    function automatic int exp_runs(input logic [W-1:0] b);
        int r;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        r = 1;
        for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
`else
        r = W;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    end

    // Waits (bounded) for done; reports busy cycles and the negedge index where done appeared.
    task automatic wait_done(output bit seen, output int busy_n, output int done_idx);
        seen = 0; busy_n = 0; done_idx = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                done_idx = i;
            end
        end
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        bit seen;
        int busy_n, done_idx, runs;
        logic [RW-1:0] exp_res;
        logic [ST_W-1:0] exp_st;
        @(posedge clk); #1;
        A = a; B = b; start = 1'b1;
        exp_q.push_back(RW'(int'(a) * int'(b)));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(seen, busy_n, done_idx);
        runs = exp_runs(b);
        exp_res = exp_q.pop_front();
        exp_st = '0;
        exp_st[ST_Z] = (exp_res == '0);
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_busy_cycles"}, busy_n, runs);
        check({tag, "_done_cycle"}, done_idx, runs + 1);
        check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        check({tag, "_status"}, {16'd0, acc_status}, {16'd0, exp_st});
    endtask

    initial begin
        bit seen;
        int busy_n, done_idx, done_cnt;

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_status", {16'd0, acc_status}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        run_mul(4'd3, 4'd5, "t1_3x5");
        run_mul(4'd15, 4'd15, "t2_15x15");
        check("t2_value", {16'd0, result}, 32'h0000_00E1);
        run_mul(4'd9, 4'd0, "t3_9x0");
        check("t3_status", {16'd0, acc_status}, 32'h0000_0001);

        // start held high through RUN, operands disturbed, then back-to-back from DONE
        @(posedge clk); #1;
        A = 4'd2; B = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        A = 4'd15; B = 4'd15;
        wait_done(seen, busy_n, done_idx);
        check("t4_done_seen", {31'd0, seen}, 32'd1);
        check("t4_busy_cycles", busy_n, exp_runs(4'd3));
        check("t4_result", {16'd0, result}, 32'd6);
        A = 4'd4; B = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_b2b_busy", {31'd0, busy}, 32'd1);
        check("t4_b2b_state", 32'(dbg_state), 32'(RUN));
        check("t4_result_held", {16'd0, result}, 32'd6);
        wait_done(seen, busy_n, done_idx);
        check("t4_b2b_done_seen", {31'd0, seen}, 32'd1);
        check("t4_b2b_done_cycle", done_idx + 1, exp_runs(4'd4) + 1);
        check("t4_b2b_result", {16'd0, result}, 32'd16);

        // reset during RUN cycle 2 aborts with no done pulse
        @(posedge clk); #1;
        A = 4'd7; B = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_result", {16'd0, result}, 32'd0);
        check("t5_state", 32'(dbg_state), 32'(IDLE));
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("t5_no_done", done_cnt, 0);

        // exhaustive sweep against A*B
        mon_en = 1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_mul(4'(a), 4'(b), "t6_sweep");
            end
        end
        mon_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
